// File: rtl/mcl_fxd_horner_seq.sv
// Sequential fixed-point Horner evaluator that drives an external shared mul-add unit.
// Optional build macro MCL_HORNER_X2_EN: run Horner in x^2, then multiply by x (odd polynomials).
//
// state     | meaning
// IDLE      | coefficient writes allowed, waiting for operand x
// SQR_ISSUE | offer x*x+0 to the mul-add unit (MCL_HORNER_X2_EN only)
// SQR_WAIT  | wait for x^2 to return (MCL_HORNER_X2_EN only)
// ISSUE     | offer acc*v+c[k] to the mul-add unit
// WAIT      | wait for the Horner step result
// FIN_ISSUE | offer acc*x+0 (MCL_HORNER_X2_EN only)
// FIN_WAIT  | wait for the final product (MCL_HORNER_X2_EN only)
// DONE      | present the result until post_get
module mcl_fxd_horner_seq #(
    parameter int FXD_Q     = 4,
    parameter int FXD_N     = 8,
    parameter int NUM_COEFF = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coef_wr_en,
    input  logic [$clog2(NUM_COEFF)-1:0] coef_wr_addr,
    input  logic [FXD_N-1:0]             coef_wr_data,
    input  logic                         pre_avail,
    output logic                         pre_get,
    input  logic [FXD_N-1:0]             pre_data,
    output logic                         post_avail,
    input  logic                         post_get,
    output logic [FXD_N-1:0]             post_data,
    output logic                         mult_avail_1,
    output logic                         mult_avail_2,
    output logic                         add_avail_1,
    input  logic                         mult_get_1,
    input  logic                         mult_get_2,
    input  logic                         add_get_1,
    output logic [FXD_N-1:0]             mult_data_1,
    output logic [FXD_N-1:0]             mult_data_2,
    output logic [FXD_N-1:0]             add_data_1,
    input  logic                         res_avail,
    output logic                         res_get,
    input  logic [FXD_N-1:0]             res_data,
    output logic                         busy
);

    localparam int AW = $clog2(NUM_COEFF);
    localparam logic [AW-1:0] K_INIT = AW'(NUM_COEFF - 2);
    localparam logic [AW:0]   NC_W   = (AW + 1)'(NUM_COEFF);

    if (NUM_COEFF < 2 || NUM_COEFF > 16 || FXD_Q >= FXD_N) begin : g_bad_param
        $error("mcl_fxd_horner_seq: illegal parameter combination");
    end

`ifdef MCL_HORNER_X2_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_SQR_ISSUE, S_SQR_WAIT, S_FIN_ISSUE, S_FIN_WAIT
    } state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
`endif

    state_t           state;
    logic [FXD_N-1:0] acc;
    logic [FXD_N-1:0] x;
    logic [FXD_N-1:0] v_op;
    logic [AW-1:0]    k;
    logic [FXD_N-1:0] coef [NUM_COEFF];
    logic             iss_avail;
    logic             issue_ok;

`ifdef MCL_HORNER_X2_EN
    logic [FXD_N-1:0] x2;
    assign v_op = x2;
`else
    assign v_op = x;
`endif

    // The three issue valids always move together, so one flop drives all of them.
    assign mult_avail_1 = iss_avail;
    assign mult_avail_2 = iss_avail;
    assign add_avail_1  = iss_avail;
    assign issue_ok     = mult_get_1 & mult_get_2 & add_get_1;

    // Operand and result buses are pure selects of registered state, so they are
    // stable while a handshake stalls and read 0 outside their owning states.
    always_comb begin
        mult_data_1 = '0;
        mult_data_2 = '0;
        add_data_1  = '0;
        post_data   = '0;
        case (state)
            S_ISSUE: begin
                mult_data_1 = acc;
                mult_data_2 = v_op;
                add_data_1  = coef[k];
            end
            S_DONE: post_data = acc;
`ifdef MCL_HORNER_X2_EN
            S_SQR_ISSUE: begin
                mult_data_1 = x;
                mult_data_2 = x;
            end
            S_FIN_ISSUE: begin
                mult_data_1 = acc;
                mult_data_2 = x;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            x          <= '0;
`ifdef MCL_HORNER_X2_EN
            x2         <= '0;
`endif
            k          <= '0;
            for (int i = 0; i < NUM_COEFF; i++) coef[i] <= '0;
            pre_get    <= 1'b0;
            post_avail <= 1'b0;
            iss_avail  <= 1'b0;
            res_get    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pre_get <= 1'b1;
                    if (coef_wr_en && ({1'b0, coef_wr_addr} < NC_W))
                        coef[coef_wr_addr] <= coef_wr_data;
                    if (pre_avail && pre_get) begin
                        x         <= pre_data;
                        acc       <= coef[NUM_COEFF-1];
                        k         <= K_INIT;
                        pre_get   <= 1'b0;
                        busy      <= 1'b1;
                        iss_avail <= 1'b1;
`ifdef MCL_HORNER_X2_EN
                        state     <= S_SQR_ISSUE;
`else
                        state     <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (issue_ok) begin
                        iss_avail <= 1'b0;
                        res_get   <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (res_avail) begin
                        acc     <= res_data;
                        res_get <= 1'b0;
                        if (k == '0) begin
`ifdef MCL_HORNER_X2_EN
                            iss_avail  <= 1'b1;
                            state      <= S_FIN_ISSUE;
`else
                            post_avail <= 1'b1;
                            state      <= S_DONE;
`endif
                        end else begin
                            k         <= k - 1'b1;
                            iss_avail <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (post_get) begin
                        post_avail <= 1'b0;
                        busy       <= 1'b0;
                        pre_get    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
`ifdef MCL_HORNER_X2_EN
                S_SQR_ISSUE: begin
                    if (issue_ok) begin
                        iss_avail <= 1'b0;
                        res_get   <= 1'b1;
                        state     <= S_SQR_WAIT;
                    end
                end
                S_SQR_WAIT: begin
                    if (res_avail) begin
                        x2        <= res_data;
                        res_get   <= 1'b0;
                        iss_avail <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_FIN_ISSUE: begin
                    if (issue_ok) begin
                        iss_avail <= 1'b0;
                        res_get   <= 1'b1;
                        state     <= S_FIN_WAIT;
                    end
                end
                S_FIN_WAIT: begin
                    if (res_avail) begin
                        acc        <= res_data;
                        res_get    <= 1'b0;
                        post_avail <= 1'b1;
                        state      <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcl_fxd_horner_seq.sv
// Scoreboard bench for mcl_fxd_horner_seq: emulated mul-add unit, random stalls,
// and a polynomial reference model evaluated directly from the coefficient table.
module tb_mcl_fxd_horner_seq;

    localparam int Q  = 4;
    localparam int N  = 8;
    localparam int NC = 3;
    localparam int AW = $clog2(NC);
`ifdef MCL_HORNER_X2_EN
    localparam int         PASSES  = NC + 1;
    localparam logic [7:0] DIR_X   = 8'h10;
    localparam logic [7:0] DIR_EXP = 8'h38;
`else
    localparam int         PASSES  = NC - 1;
    localparam logic [7:0] DIR_X   = 8'h20;
    localparam logic [7:0] DIR_EXP = 8'h70;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          coef_wr_en;
    logic [AW-1:0] coef_wr_addr;
    logic [N-1:0]  coef_wr_data;
    logic          pre_avail, pre_get;
    logic [N-1:0]  pre_data;
    logic          post_avail, post_get;
    logic [N-1:0]  post_data;
    logic          mult_avail_1, mult_avail_2, add_avail_1;
    logic          mult_get_1, mult_get_2, add_get_1;
    logic [N-1:0]  mult_data_1, mult_data_2, add_data_1;
    logic          res_avail, res_get;
    logic [N-1:0]  res_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] ref_c [NC];
    logic [N-1:0] exp_q [$];
    int issue_cnt = 0;
    int done_cnt  = 0;
    int base_issue, base_done;
    int lat = 1;
    int g2_req = 0;
    int stall_req = 0;

    mcl_fxd_horner_seq #(.FXD_Q(Q), .FXD_N(N), .NUM_COEFF(NC)) dut (
        .clk(clk), .rst(rst),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .pre_avail(pre_avail), .pre_get(pre_get), .pre_data(pre_data),
        .post_avail(post_avail), .post_get(post_get), .post_data(post_data),
        .mult_avail_1(mult_avail_1), .mult_avail_2(mult_avail_2), .add_avail_1(add_avail_1),
        .mult_get_1(mult_get_1), .mult_get_2(mult_get_2), .add_get_1(add_get_1),
        .mult_data_1(mult_data_1), .mult_data_2(mult_data_2), .add_data_1(add_data_1),
        .res_avail(res_avail), .res_get(res_get), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Signed Q-format multiply-add as performed by the external unit.
    function automatic logic [N-1:0] fxd_fma(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] c);
        logic signed [2*N-1:0] p;
        p = $signed(a) * $signed(b);
        p = p >>> Q;
        return p[N-1:0] + c;
    endfunction

    function automatic logic [N-1:0] poly_ref(input logic [N-1:0] xv);
        logic [N-1:0] v, acc;
`ifdef MCL_HORNER_X2_EN
        v = fxd_fma(xv, xv, '0);
`else
        v = xv;
`endif
        acc = ref_c[NC-1];
        for (int i = NC - 2; i >= 0; i--) acc = fxd_fma(acc, v, ref_c[i]);
`ifdef MCL_HORNER_X2_EN
        acc = fxd_fma(acc, xv, '0);
`endif
        return acc;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_flags"}, int'({pre_get, post_avail, mult_avail_1, mult_avail_2,
                                         add_avail_1, res_get, busy}), 0);
        check_int({tag, "_data"}, int'({post_data, mult_data_1, mult_data_2, add_data_1}), 0);
    endtask

    // Emulated shared mul-add unit: random accept stalls, result after `lat` cycles.
    initial begin : mul_add
        logic [N-1:0] op1, op2, op3, val, s1, s2, s3;
        logic fire, pend, ret_fire, snap_v;
        int cnt, g2_left, g2_seen;
        fire = 0; pend = 0; ret_fire = 0; snap_v = 0; cnt = 0; g2_left = 0; g2_seen = 0;
        op1 = '0; op2 = '0; op3 = '0; val = '0; s1 = '0; s2 = '0; s3 = '0;
        mult_get_1 = 0; mult_get_2 = 0; add_get_1 = 0; res_avail = 0; res_data = '0;
        forever begin
            @(negedge clk);
            if (g2_req != g2_seen) begin g2_seen = g2_req; g2_left = 5; end
            if (rst || !busy) begin
                fire = 0; pend = 0; ret_fire = 0; snap_v = 0;
                mult_get_1 = 0; mult_get_2 = 0; add_get_1 = 0;
                if (!rst) res_avail = 0;
                continue;
            end
            if (ret_fire) begin res_avail = 0; ret_fire = 0; end
            if (fire) begin
                pend = 1; cnt = lat; val = fxd_fma(op1, op2, op3); fire = 0; issue_cnt++;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin res_avail = 1; res_data = val; pend = 0; end
            end
            if (snap_v) begin
                check_int("issue_hold", int'({mult_avail_1, mult_avail_2, add_avail_1,
                                              mult_data_1, mult_data_2, add_data_1}),
                          int'({3'b111, s1, s2, s3}));
                snap_v = 0;
            end
            mult_get_1 = ($urandom_range(0, 3) != 0);
            mult_get_2 = ($urandom_range(0, 3) != 0);
            add_get_1  = ($urandom_range(0, 3) != 0);
            if (mult_avail_1 && mult_avail_2 && add_avail_1) begin
                if (g2_left > 0) begin mult_get_2 = 0; g2_left--; end
                if (mult_get_1 && mult_get_2 && add_get_1) begin
                    fire = 1; op1 = mult_data_1; op2 = mult_data_2; op3 = add_data_1;
                end else begin
                    snap_v = 1; s1 = mult_data_1; s2 = mult_data_2; s3 = add_data_1;
                end
            end
            if (res_avail && res_get) ret_fire = 1;
        end
    end

    // Result monitor: random post_get back-pressure, pops expected values.
    initial begin : monitor
        logic [N-1:0] psnap;
        logic pv;
        int stall_left, stall_seen;
        pv = 0; psnap = '0; stall_left = 0; stall_seen = 0;
        post_get = 0;
        forever begin
            @(negedge clk);
            if (rst) begin post_get = 0; pv = 0; stall_left = 0; continue; end
            if (pv) begin
                check_int("post_hold", int'({post_avail, post_data}), int'({1'b1, psnap}));
                pv = 0;
            end
            if (stall_req != stall_seen) begin stall_seen = stall_req; stall_left = 4; end
            post_get = 0;
            if (post_avail) begin
                if (stall_left > 0) stall_left--;
                else post_get = ($urandom_range(0, 1) == 1);
                if (post_get) begin
                    check_int("post_expected_pending", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check_int("post_data", int'(post_data),
                                                     int'(exp_q.pop_front()));
                    done_cnt++;
                end else begin
                    pv = 1; psnap = post_data;
                end
            end
        end
    end

    task automatic write_coef(input logic [AW-1:0] a, input logic [N-1:0] d, input bit idle);
        coef_wr_en = 1; coef_wr_addr = a; coef_wr_data = d;
        if (idle && (int'(a) < NC)) ref_c[a] = d;
        @(negedge clk);
        coef_wr_en = 0;
    endtask

    task automatic start_x(input logic [N-1:0] xv, input logic [N-1:0] ev);
        int t;
        t = 0;
        while (!pre_get && t < 50) begin @(negedge clk); t++; end
        check_int("pre_get_ready", int'(pre_get), 1);
        exp_q.push_back(ev);
        base_issue = issue_cnt;
        base_done  = done_cnt;
        pre_avail = 1; pre_data = xv;
        @(negedge clk);
        pre_avail = 0; pre_data = N'($urandom);
    endtask

    task automatic finish_run();
        int t, busy_low;
        t = 0; busy_low = 0;
        while (done_cnt == base_done && t < 400) begin
            if (!busy) busy_low++;
            @(negedge clk); t++;
        end
        check_int("run_complete", int'(t < 400), 1);
        check_int("busy_run", busy_low, 0);
        @(negedge clk);
        check_int("busy_idle", int'(busy), 0);
        check_int("issue_count", issue_cnt - base_issue, PASSES);
    endtask

    task automatic run_x(input logic [N-1:0] xv, input logic [N-1:0] ev);
        start_x(xv, ev);
        finish_run();
    endtask

    initial begin : stim
        int t;
        logic [N-1:0] xv;
        rst = 1; coef_wr_en = 0; coef_wr_addr = '0; coef_wr_data = '0;
        pre_avail = 0; pre_data = '0;
        for (int i = 0; i < NC; i++) ref_c[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        @(negedge clk);
        check_int("pre_get_after_reset", int'(pre_get), 1);

        write_coef(2'd0, 8'h10, 1);
        write_coef(2'd1, 8'h20, 1);
        write_coef(2'd2, 8'h08, 1);
        run_x(DIR_X, DIR_EXP);

        write_coef(2'd3, 8'h77, 1);
        run_x(DIR_X, DIR_EXP);

        g2_req++;
        run_x(DIR_X, DIR_EXP);

        stall_req++;
        start_x(DIR_X, DIR_EXP);
        t = 0;
        while (!post_avail && t < 100) begin @(negedge clk); t++; end
        check_int("reached_done", int'(post_avail), 1);
        check_int("pre_get_in_done", int'(pre_get), 0);
        write_coef(2'd0, 8'h55, 0);
        finish_run();
        run_x(DIR_X, DIR_EXP);

        start_x(DIR_X, DIR_EXP);
        t = 0;
        while (!res_get && t < 100) begin @(negedge clk); t++; end
        check_int("reached_wait", int'(res_get), 1);
        #2 rst = 1;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        for (int i = 0; i < NC; i++) ref_c[i] = '0;
        @(negedge clk);
        check_int("pre_get_in_reset", int'(pre_get), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_int("pre_get_after_reset2", int'(pre_get), 1);
        run_x(8'h10, 8'h00);

        for (int r = 0; r < 40; r++) begin
            lat = $urandom_range(1, 3);
            for (int w = 0; w < int'($urandom_range(1, 3)); w++)
                write_coef(AW'($urandom_range(0, 3)), N'($urandom), 1);
            xv = N'($urandom);
            run_x(xv, poly_ref(xv));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
